// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues npc to instruction memory with one outstanding
// access, returns the word to prediction and buffers {pc, inst} for DECODE.
module fetch_stage #(
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc,
   input  logic        br_late,
   output logic        fetch_stall,
   output logic [31:0] inst_feedback,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        dec_valid,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_inst,
   output logic        dec_misalign,
   input  logic        dec_ready
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   req_pc_q, req_pc_d;
   logic              req_mis_q, req_mis_d;
   logic              dec_valid_q, dec_valid_d;
   logic [XLEN-1:0]   dec_pc_q, dec_pc_d;
   logic [XLEN-1:0]   dec_inst_q, dec_inst_d;
   logic              dec_mis_q, dec_mis_d;

   logic resp;
   logic slot_free;
   logic can_issue;
   logic grant;
   logic load;

   // Handshake qualifiers; reset forces the request port idle.
   always_comb begin
      resp      = (state_q == ST_WAIT) & imem_rvalid;
      slot_free = ~dec_valid_q | dec_ready;
      can_issue = rst & ~br_late & slot_free & ((state_q == ST_IDLE) | resp);
      grant     = can_issue & imem_gnt;
      load      = resp & ~br_late;
   end

   assign imem_req      = can_issue;
   assign imem_addr     = {npc[XLEN-1:2], 2'b00};
   assign fetch_stall   = ~grant;
   assign inst_feedback = resp ? imem_rdata : NOP_INST;

   assign dec_valid     = dec_valid_q;
   assign dec_pc        = dec_pc_q;
   assign dec_inst      = dec_inst_q;
   assign dec_misalign  = dec_mis_q;

   // Next-state logic for the outstanding-access tracker.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (grant) state_d = ST_WAIT;
         ST_WAIT: begin
            if (br_late)    state_d = imem_rvalid ? ST_IDLE : ST_DROP;
            else if (resp)  state_d = grant ? ST_WAIT : ST_IDLE;
         end
         ST_DROP: if (imem_rvalid) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Request tag capture and output-entry update; flush outranks load.
   always_comb begin
      req_pc_d    = req_pc_q;
      req_mis_d   = req_mis_q;
      dec_valid_d = dec_valid_q;
      dec_pc_d    = dec_pc_q;
      dec_inst_d  = dec_inst_q;
      dec_mis_d   = dec_mis_q;

      if (grant) begin
         req_pc_d  = npc;
         req_mis_d = |npc[1:0];
      end

      if (br_late) begin
         dec_valid_d = 1'b0;
      end else if (load) begin
         dec_valid_d = 1'b1;
         dec_pc_d    = req_pc_q;
         dec_inst_d  = imem_rdata;
         dec_mis_d   = req_mis_q;
      end else if (dec_valid_q & dec_ready) begin
         dec_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         req_pc_q    <= '0;
         req_mis_q   <= 1'b0;
         dec_valid_q <= 1'b0;
         dec_pc_q    <= '0;
         dec_inst_q  <= '0;
         dec_mis_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_pc_q    <= req_pc_d;
         req_mis_q   <= req_mis_d;
         dec_valid_q <= dec_valid_d;
         dec_pc_q    <= dec_pc_d;
         dec_inst_q  <= dec_inst_d;
         dec_mis_q   <= dec_mis_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: per-cycle table plus hand sequences
// for reset, multi-cycle latency and reset during an outstanding access.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] npc;
   logic        br_late;
   logic        fetch_stall;
   logic [31:0] inst_feedback;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        dec_valid;
   logic [31:0] dec_pc;
   logic [31:0] dec_inst;
   logic        dec_misalign;
   logic        dec_ready;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fetch_stage #(.NOP_INST(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .npc           (npc),
      .br_late       (br_late),
      .fetch_stall   (fetch_stall),
      .inst_feedback (inst_feedback),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .dec_valid     (dec_valid),
      .dec_pc        (dec_pc),
      .dec_inst      (dec_inst),
      .dec_misalign  (dec_misalign),
      .dec_ready     (dec_ready)
   );

   typedef struct {
      logic [31:0] npc;
      logic        brl;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        rdy;
      logic        e_stall;
      logic        e_req;
      logic [31:0] e_fb;
      logic        e_dv;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_mis;
   } vec_t;

   function automatic vec_t mk(logic [31:0] n, logic b, logic g, logic r, logic [31:0] d,
                               logic y, logic es, logic eq, logic [31:0] ef, logic ev,
                               logic [31:0] ep, logic [31:0] ei, logic em);
      vec_t v;
      v.npc = n; v.brl = b; v.gnt = g; v.rv = r; v.rdata = d; v.rdy = y;
      v.e_stall = es; v.e_req = eq; v.e_fb = ef; v.e_dv = ev;
      v.e_pc = ep; v.e_inst = ei; v.e_mis = em;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic drive(input logic r, input logic [31:0] n, input logic b, input logic g,
                        input logic v, input logic [31:0] d, input logic y);
      @(negedge clk);
      rst = r; npc = n; br_late = b; imem_gnt = g; imem_rvalid = v; imem_rdata = d;
      dec_ready = y;
      #1;
   endtask

   vec_t vecs[26];

   initial begin
      rst = 1'b0; npc = 32'h1000; br_late = 1'b0; imem_gnt = 1'b1;
      imem_rvalid = 1'b0; imem_rdata = 32'h0; dec_ready = 1'b1;

      //             npc        brl gnt rv rdata         rdy  stall req fb            dv pc         inst          mis
      vecs[0]  = mk(32'h1000, 0, 1, 0, 32'h0,        1,   0, 1, 32'h0,        0, 32'h0,    32'h0,        0);
      vecs[1]  = mk(32'h1004, 0, 1, 1, 32'hA000_0000,1,   0, 1, 32'hA000_0000,0, 32'h0,    32'h0,        0);
      vecs[2]  = mk(32'h1008, 0, 1, 1, 32'hA000_0001,1,   0, 1, 32'hA000_0001,1, 32'h1000, 32'hA000_0000,0);
      vecs[3]  = mk(32'h100C, 0, 0, 1, 32'hA000_0002,1,   1, 1, 32'hA000_0002,1, 32'h1004, 32'hA000_0001,0);
      vecs[4]  = mk(32'h100C, 0, 1, 0, 32'h0,        0,   1, 0, 32'h0,        1, 32'h1008, 32'hA000_0002,0);
      vecs[5]  = mk(32'h100C, 0, 1, 0, 32'h0,        0,   1, 0, 32'h0,        1, 32'h1008, 32'hA000_0002,0);
      vecs[6]  = mk(32'h100C, 0, 1, 0, 32'h0,        0,   1, 0, 32'h0,        1, 32'h1008, 32'hA000_0002,0);
      vecs[7]  = mk(32'h100C, 0, 1, 0, 32'h0,        0,   1, 0, 32'h0,        1, 32'h1008, 32'hA000_0002,0);
      vecs[8]  = mk(32'h100C, 0, 1, 0, 32'h0,        1,   0, 1, 32'h0,        1, 32'h1008, 32'hA000_0002,0);
      vecs[9]  = mk(32'h1010, 0, 1, 0, 32'h0,        1,   1, 0, 32'h0,        0, 32'h0,    32'h0,        0);
      vecs[10] = mk(32'h1010, 1, 1, 0, 32'h0,        1,   1, 0, 32'h0,        0, 32'h0,    32'h0,        0);
      vecs[11] = mk(32'h2000, 0, 1, 0, 32'h0,        1,   1, 0, 32'h0,        0, 32'h0,    32'h0,        0);
      vecs[12] = mk(32'h2000, 0, 1, 1, 32'hDEAD_BEEF,1,   1, 0, 32'h0,        0, 32'h0,    32'h0,        0);
      vecs[13] = mk(32'h2000, 0, 1, 0, 32'h0,        1,   0, 1, 32'h0,        0, 32'h0,    32'h0,        0);
      vecs[14] = mk(32'h2004, 0, 0, 1, 32'hB000_0000,1,   1, 1, 32'hB000_0000,0, 32'h0,    32'h0,        0);
      vecs[15] = mk(32'h2004, 0, 1, 0, 32'h0,        1,   0, 1, 32'h0,        1, 32'h2000, 32'hB000_0000,0);
      vecs[16] = mk(32'h2004, 1, 1, 1, 32'hC000_0000,1,   1, 0, 32'hC000_0000,0, 32'h0,    32'h0,        0);
      vecs[17] = mk(32'h3000, 0, 1, 0, 32'h0,        1,   0, 1, 32'h0,        0, 32'h0,    32'h0,        0);
      vecs[18] = mk(32'h3004, 0, 0, 1, 32'hD000_0000,0,   1, 1, 32'hD000_0000,0, 32'h0,    32'h0,        0);
      vecs[19] = mk(32'h3004, 1, 1, 0, 32'h0,        0,   1, 0, 32'h0,        1, 32'h3000, 32'hD000_0000,0);
      vecs[20] = mk(32'h3004, 0, 0, 0, 32'h0,        0,   1, 1, 32'h0,        0, 32'h0,    32'h0,        0);
      vecs[21] = mk(32'h1002, 0, 1, 0, 32'h0,        1,   0, 1, 32'h0,        0, 32'h0,    32'h0,        0);
      vecs[22] = mk(32'h1006, 0, 0, 1, 32'hE000_0000,1,   1, 1, 32'hE000_0000,0, 32'h0,    32'h0,        0);
      vecs[23] = mk(32'h1006, 0, 0, 0, 32'h0,        1,   1, 1, 32'h0,        1, 32'h1002, 32'hE000_0000,1);
      vecs[24] = mk(32'h1006, 0, 0, 1, 32'hF000_0000,1,   1, 1, 32'h0,        0, 32'h0,    32'h0,        0);
      vecs[25] = mk(32'h1006, 0, 0, 0, 32'h0,        1,   1, 1, 32'h0,        0, 32'h0,    32'h0,        0);

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h1000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
         chk("rst_req", 32'(imem_req), 32'h0);
         chk("rst_stall", 32'(fetch_stall), 32'h1);
         if (i > 0) begin
            chk("rst_dv", 32'(dec_valid), 32'h0);
            chk("rst_pc", dec_pc, 32'h0);
            chk("rst_inst", dec_inst, 32'h0);
            chk("rst_mis", 32'(dec_misalign), 32'h0);
         end
      end

      for (int i = 0; i < 26; i++) begin
         drive(1'b1, vecs[i].npc, vecs[i].brl, vecs[i].gnt, vecs[i].rv, vecs[i].rdata,
               vecs[i].rdy);
         chk($sformatf("v%0d_stall", i), 32'(fetch_stall), 32'(vecs[i].e_stall));
         chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
         chk($sformatf("v%0d_fb", i), inst_feedback, vecs[i].e_fb);
         chk($sformatf("v%0d_dv", i), 32'(dec_valid), 32'(vecs[i].e_dv));
         if (vecs[i].e_req)
            chk($sformatf("v%0d_addr", i), imem_addr, {vecs[i].npc[31:2], 2'b00});
         if (vecs[i].e_dv) begin
            chk($sformatf("v%0d_pc", i), dec_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_inst", i), dec_inst, vecs[i].e_inst);
            chk($sformatf("v%0d_mis", i), 32'(dec_misalign), 32'(vecs[i].e_mis));
         end
      end

      // Latency k=3: grant, two waiting cycles, response, entry one cycle later.
      drive(1'b1, 32'h4000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("k3_grant_stall", 32'(fetch_stall), 32'h0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h4004, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
         chk("k3_wait_stall", 32'(fetch_stall), 32'h1);
         chk("k3_wait_dv", 32'(dec_valid), 32'h0);
      end
      drive(1'b1, 32'h4004, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
      chk("k3_fb", inst_feedback, 32'h1234_5678);
      chk("k3_resp_dv", 32'(dec_valid), 32'h0);
      drive(1'b1, 32'h4004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("k3_dv", 32'(dec_valid), 32'h1);
      chk("k3_pc", dec_pc, 32'h4000);
      chk("k3_inst", dec_inst, 32'h1234_5678);

      // Reset while an access is outstanding returns to IDLE with a clear entry.
      drive(1'b1, 32'h5000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("rw_grant_stall", 32'(fetch_stall), 32'h0);
      drive(1'b0, 32'h5004, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("rw_rst_req", 32'(imem_req), 32'h0);
      chk("rw_rst_stall", 32'(fetch_stall), 32'h1);
      drive(1'b1, 32'h5004, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("rw_idle_req", 32'(imem_req), 32'h1);
      chk("rw_idle_stall", 32'(fetch_stall), 32'h0);
      chk("rw_dv", 32'(dec_valid), 32'h0);
      chk("rw_pc", dec_pc, 32'h0);
      chk("rw_inst", dec_inst, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
